regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32x32 register file. Shares the register file's single write port among NREQ write-back requesters (ALU, load unit, multiply/divide) with round-robin arbitration and a registered write-port drive. Tracks in-flight destination registers in a 32-bit pending scoreboard so the issue stage can detect RAW hazards on Rs1/Rs2. Sits between the execute/memory units and the register file's RegWrite/Rd/Write_data inputs.

## Interface
- NREQ, 3, number of write-back requesters (2..4)
- XLEN, 32, data width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has a write-back pending
- req_ready  out  NREQ  one-hot grant; transfer when valid & ready
- req_rd  in  5*NREQ  destination of requester i at bits [5i+4:5i]
- req_data  in  XLEN*NREQ  data of requester i at bits [XLEN*i+XLEN-1:XLEN*i]
- RegWrite  out  1  register-file write enable (registered)
- Rd  out  5  register-file write address (registered)
- Write_data  out  XLEN  register-file write data (registered)
- issue_valid  in  1  instruction issued this cycle with a destination
- issue_rd  in  5  destination of the issued instruction
- Rs1, Rs2  in  5  source registers queried by the issue stage
- busy1, busy2  out  1  Rs1/Rs2 has a pending write (combinational)

## Operation
- Reset: ptr=0, pending=0, RegWrite=0, Rd=0, Write_data=0; req_ready=0 while rst is high.
- Arbitration (combinational): scan requesters from ptr upward modulo NREQ; first with req_valid high gets req_ready=1; all others 0. At most one grant per cycle. No valid request -> req_ready=0.
- Pointer update on an accepted grant to i: ptr <= (i+1) mod NREQ. No grant -> ptr holds.
- Output register, every cycle: RegWrite <= grant taken && granted rd != 0; Rd <= granted rd; Write_data <= granted data. With no grant, RegWrite <= 0 and Rd/Write_data hold.
- Grant with rd == 0: accepted (ready=1, ptr advances), RegWrite stays 0, scoreboard untouched.
- Scoreboard pending[31:0], bit 0 permanently 0:
  - set: issue_valid && issue_rd != 0 -> pending[issue_rd] <= 1.
  - clear: RegWrite==1 -> pending[Rd] <= 0 on the same edge the register file commits.
  - set and clear of the same register in one cycle: set wins.
  - clearing an already-clear bit: no-op; setting an already-set bit: stays set (issue stage must not issue WAW to a busy rd).
- busy1 = pending[Rs1]; busy2 = pending[Rs2]; index 0 always returns 0.
- Requester data/rd may change freely while its valid is low; while valid & !ready they must hold.

## Timing
- Grant at cycle T -> RegWrite/Rd/Write_data valid in T+1 -> register file writes at end of T+1 -> pending bit clears at end of T+1 -> busy low and the new value readable from T+2.
- Throughput: one write-back per cycle, sustained.
- Issue at cycle T -> busy visible from T+1.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once in every NREQ consecutive cycles.
- rst asserted mid-stream: on that edge pending clears, RegWrite goes 0, ptr=0; a write latched in the output register in the rst cycle is discarded (RegWrite is 0 the following cycle).

## Test plan
- Reset: rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, RegWrite=0, busy1=busy2=0 throughout; after release, first grant goes to requester 0.
- Single write: issue_rd=5 at T0, requester 1 presents rd=5, data=0xDEADBEEF at T2 -> ready[1]=1 at T2, RegWrite=1/Rd=5/Write_data=0xDEADBEEF at T3, busy1 (Rs1=5) high T1..T3, low at T4.
- Round-robin: all three valid continuously with rd=1,2,3 -> grant order 0,1,2,0,1,2; Rd sequence 1,2,3,1,2,3 one per cycle, RegWrite=1 every cycle.
- rd=0: requester 2 valid with rd=0, data=0x1234 -> ready[2]=1, RegWrite=0 next cycle, pending unchanged, ptr advances to 0.
- Set/clear collision: pending[7]=1, write-back to x7 emitted (RegWrite=1, Rd=7) in the same cycle issue_valid=1, issue_rd=7 -> pending[7] stays 1, busy for Rs1=7 remains high.
- Reset mid-operation: rst=1 in the cycle a grant to rd=9 occurs with pending[9]=1 -> next cycle RegWrite=0, pending[9]=0, ptr=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Write-back arbiter and pending-write scoreboard for the 32x32 register
//   file. NREQ write-back requesters share the register file's single write
//   port. Arbitration is round-robin and the write-port drive is registered.
//   A 32-bit scoreboard records destination registers that have been issued
//   but not yet written back, so the issue stage can see RAW hazards on
//   Rs1/Rs2.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   req_valid    [NREQ]        requester i has a write-back pending
//   req_ready    [NREQ]        one-hot grant; transfer when valid & ready
//   req_rd       [5*NREQ]      destination of requester i at [5i+4:5i]
//   req_data     [XLEN*NREQ]   data of requester i at [XLEN*i +: XLEN]
//   RegWrite                   register-file write enable (registered)
//   Rd           [5]           register-file write address (registered)
//   Write_data   [XLEN]        register-file write data (registered)
//   issue_valid                instruction issued this cycle with a destination
//   issue_rd     [5]           destination of the issued instruction
//   Rs1, Rs2     [5]           source registers queried by the issue stage
//   busy1, busy2               Rs1/Rs2 has a pending write (combinational)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int unsigned NREQ = 3,
   parameter int unsigned XLEN = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [5*NREQ-1:0]      req_rd,
   input  logic [XLEN*NREQ-1:0]   req_data,
   output logic                   RegWrite,
   output logic [4:0]             Rd,
   output logic [XLEN-1:0]        Write_data,
   input  logic                   issue_valid,
   input  logic [4:0]             issue_rd,
   input  logic [4:0]             Rs1,
   input  logic [4:0]             Rs2,
   output logic                   busy1,
   output logic                   busy2
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Round-robin pointer: requester with highest priority this cycle.
   logic [PW-1:0]   ptr_q, ptr_d;

   // Arbitration results.
   logic [NREQ-1:0] gnt;
   logic            gnt_any;
   logic [4:0]      gnt_rd;
   logic [XLEN-1:0] gnt_data;

   // Registered write-port drive.
   logic            wr_en_q, wr_en_d;
   logic [4:0]      wr_rd_q, wr_rd_d;
   logic [XLEN-1:0] wr_data_q, wr_data_d;

   // Pending-write scoreboard, bit 0 is never set.
   logic [31:0]     pending_q, pending_d;

   // --------------------------------------------------------------------------
   // Arbitration: scan from ptr upward modulo NREQ, first valid wins.
   // Grants are suppressed while rst is high.
   // --------------------------------------------------------------------------
   always_comb begin : arbiter
      logic [PW-1:0] idx;
      gnt     = '0;
      gnt_any = 1'b0;
      ptr_d   = ptr_q;
      idx     = '0;
      if (!rst) begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PW'((32'(ptr_q) + k) % NREQ);
            if (!gnt_any && req_valid[idx]) begin
               gnt_any  = 1'b1;
               gnt[idx] = 1'b1;
               ptr_d    = PW'((32'(idx) + 1) % NREQ);
            end
         end
      end
   end

   // One-hot mux of the granted requester's destination and data.
   always_comb begin : grant_mux
      gnt_rd   = '0;
      gnt_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            gnt_rd   = req_rd[5*i +: 5];
            gnt_data = req_data[XLEN*i +: XLEN];
         end
      end
   end

   assign req_ready = gnt;

   // --------------------------------------------------------------------------
   // Write-port next state. A grant to x0 is still accepted but never
   // asserts the write enable. Without a grant the address/data hold.
   // --------------------------------------------------------------------------
   always_comb begin : wr_next
      wr_en_d   = 1'b0;
      wr_rd_d   = wr_rd_q;
      wr_data_d = wr_data_q;
      if (gnt_any) begin
         wr_en_d   = (gnt_rd != 5'd0);
         wr_rd_d   = gnt_rd;
         wr_data_d = gnt_data;
      end
   end

   // --------------------------------------------------------------------------
   // Scoreboard next state. Clear happens on the edge the register file
   // commits; a same-cycle issue to the same register is applied afterwards
   // so the set wins.
   // --------------------------------------------------------------------------
   always_comb begin : sb_next
      pending_d = pending_q;
      if (wr_en_q) begin
         pending_d[wr_rd_q] = 1'b0;
      end
      if (issue_valid && (issue_rd != 5'd0)) begin
         pending_d[issue_rd] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_rd_q   <= '0;
         wr_data_q <= '0;
         pending_q <= '0;
      end else begin
         ptr_q     <= ptr_d;
         wr_en_q   <= wr_en_d;
         wr_rd_q   <= wr_rd_d;
         wr_data_q <= wr_data_d;
         pending_q <= pending_d;
      end
   end

   assign RegWrite   = wr_en_q;
   assign Rd         = wr_rd_q;
   assign Write_data = wr_data_q;

   assign busy1 = pending_q[Rs1];
   assign busy2 = pending_q[Rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

   localparam int unsigned NREQ = 3;
   localparam int unsigned XLEN = 32;

   logic                 clk;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [5*NREQ-1:0]    req_rd;
   logic [XLEN*NREQ-1:0] req_data;
   logic                 RegWrite;
   logic [4:0]           Rd;
   logic [XLEN-1:0]      Write_data;
   logic                 issue_valid;
   logic [4:0]           issue_rd;
   logic [4:0]           Rs1;
   logic [4:0]           Rs2;
   logic                 busy1;
   logic                 busy2;

   regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_rd      (req_rd),
      .req_data    (req_data),
      .RegWrite    (RegWrite),
      .Rd          (Rd),
      .Write_data  (Write_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .Rs1         (Rs1),
      .Rs2         (Rs2),
      .busy1       (busy1),
      .busy2       (busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   wb_t exp_q[$];
   int  total = 0;
   int  bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
      wb_t e;
      e.rd   = rd;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] d);
      req_rd[5*i +: 5]   = rd;
      req_data[32*i +: 32] = d;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Monitor: every register-file write must match the next expected one.
   always @(negedge clk) begin
      if (RegWrite === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wb_unexpected: got Rd=%0d data=%h expected no write", Rd, Write_data);
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            chk("wb_rd", 32'(Rd), 32'(e.rd));
            chk("wb_data", Write_data, e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      req_valid   = '0;
      req_rd      = '0;
      req_data    = '0;
      issue_valid = 1'b0;
      issue_rd    = '0;
      Rs1         = '0;
      Rs2         = '0;

      // ---------------- reset with all requesters valid ----------------
      next_cycle();
      req_valid = 3'b111;
      set_req(0, 5'd1, 32'hA000_0001);
      set_req(1, 5'd2, 32'hA000_0002);
      set_req(2, 5'd3, 32'hA000_0003);
      Rs1 = 5'd1;
      Rs2 = 5'd2;
      for (int c = 0; c < 2; c++) begin
         if (c > 0) next_cycle();
         sample();
         chk("rst_ready", 32'(req_ready), 32'd0);
         chk("rst_regwrite", 32'(RegWrite), 32'd0);
         chk("rst_busy1", 32'(busy1), 32'd0);
         chk("rst_busy2", 32'(busy2), 32'd0);
      end
      next_cycle();
      rst = 1'b0;
      sample();
      chk("first_grant", 32'(req_ready), 32'b001);
      push_wb(5'd1, 32'hA000_0001);            // ptr -> 1
      next_cycle();
      req_valid = '0;

      // ---------------- single write with scoreboard ----------------
      issue_valid = 1'b1;                      // T0
      issue_rd    = 5'd5;
      Rs1         = 5'd5;
      Rs2         = 5'd0;
      sample();
      chk("sw_busy_T0", 32'(busy1), 32'd0);
      next_cycle();                            // T1
      issue_valid = 1'b0;
      sample();
      chk("sw_busy_T1", 32'(busy1), 32'd1);
      chk("busy_x0", 32'(busy2), 32'd0);
      next_cycle();                            // T2
      req_valid = 3'b010;
      set_req(1, 5'd5, 32'hDEAD_BEEF);
      sample();
      chk("sw_ready_T2", 32'(req_ready), 32'b010);
      chk("sw_busy_T2", 32'(busy1), 32'd1);
      push_wb(5'd5, 32'hDEAD_BEEF);            // ptr -> 2
      next_cycle();                            // T3
      req_valid = '0;
      sample();
      chk("sw_busy_T3", 32'(busy1), 32'd1);
      next_cycle();                            // T4
      sample();
      chk("sw_busy_T4", 32'(busy1), 32'd0);

      // ---------------- grant to rd=0 ----------------
      next_cycle();
      req_valid   = 3'b100;
      set_req(2, 5'd0, 32'h0000_1234);
      issue_valid = 1'b1;
      issue_rd    = 5'd12;
      sample();
      chk("rd0_ready", 32'(req_ready), 32'b100);   // ptr -> 0, no write expected
      next_cycle();
      req_valid   = '0;
      issue_valid = 1'b0;
      Rs1         = 5'd12;
      sample();
      chk("rd0_regwrite", 32'(RegWrite), 32'd0);
      chk("rd0_pending_kept", 32'(busy1), 32'd1);

      // ---------------- round-robin, all valid ----------------
      next_cycle();
      req_valid = 3'b111;
      set_req(0, 5'd1, 32'h1111_0000);
      set_req(1, 5'd2, 32'h2222_0000);
      set_req(2, 5'd3, 32'h3333_0000);
      for (int c = 0; c < 6; c++) begin
         if (c > 0) next_cycle();
         sample();
         chk("rr_ready", 32'(req_ready), 32'(1 << (c % 3)));
         case (c % 3)
            0: push_wb(5'd1, 32'h1111_0000);
            1: push_wb(5'd2, 32'h2222_0000);
            default: push_wb(5'd3, 32'h3333_0000);
         endcase
      end
      next_cycle();
      req_valid = '0;                          // ptr back at 0

      // ---------------- set/clear collision on x7 ----------------
      issue_valid = 1'b1;                      // T0
      issue_rd    = 5'd7;
      next_cycle();                            // T1
      issue_valid = 1'b0;
      next_cycle();                            // T2
      req_valid = 3'b001;
      set_req(0, 5'd7, 32'h0000_0077);
      sample();
      chk("col_ready", 32'(req_ready), 32'b001);
      push_wb(5'd7, 32'h0000_0077);            // ptr -> 1
      next_cycle();                            // T3: write of x7 presented
      req_valid   = '0;
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      next_cycle();                            // T4
      issue_valid = 1'b0;
      Rs1         = 5'd7;
      sample();
      chk("col_busy_kept", 32'(busy1), 32'd1);

      // ---------------- reset mid-operation ----------------
      next_cycle();
      issue_valid = 1'b1;
      issue_rd    = 5'd9;
      next_cycle();                            // grant x9 to requester 1
      issue_valid = 1'b0;
      Rs1         = 5'd9;
      Rs2         = 5'd7;
      req_valid   = 3'b010;
      set_req(1, 5'd9, 32'h0000_0999);
      sample();
      chk("mr_ready", 32'(req_ready), 32'b010);
      chk("mr_busy9", 32'(busy1), 32'd1);
      push_wb(5'd9, 32'h0000_0999);            // ptr -> 2
      next_cycle();                            // rst cycle, x9 write on port
      rst       = 1'b1;
      req_valid = 3'b100;
      set_req(2, 5'd9, 32'h0000_0AAA);
      sample();
      chk("mr_rst_ready", 32'(req_ready), 32'd0);
      next_cycle();
      rst       = 1'b0;
      req_valid = 3'b111;
      set_req(0, 5'd1, 32'h5555_0001);
      set_req(1, 5'd2, 32'h5555_0002);
      set_req(2, 5'd3, 32'h5555_0003);
      sample();
      chk("mr_regwrite", 32'(RegWrite), 32'd0);
      chk("mr_busy9_clr", 32'(busy1), 32'd0);
      chk("mr_busy7_clr", 32'(busy2), 32'd0);
      chk("mr_ptr0", 32'(req_ready), 32'b001);
      push_wb(5'd1, 32'h5555_0001);
      next_cycle();
      req_valid = '0;
      next_cycle();
      next_cycle();
      sample();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
